// File: rtl/tt_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tt_mux_pkg                                             |
// | Description : Shared types and constants for the project-slot mux.   |
// |               State encoding, packed input-word bit positions and    |
// |               default word widths.                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package tt_mux_pkg;

  // Controller sequence: idle, one-cycle disable, held reset, run
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFF   = 2'd1,
    RESET = 2'd2,
    RUN   = 2'd3
  } state_e;

  // Bit positions inside the packed input word {uio_in, ui_in, rst_n, clk}
  localparam int IW_CLK_BIT  = 0;
  localparam int IW_RSTN_BIT = 1;

  // Default packed word widths
  localparam int DEF_IW_W = 18;
  localparam int DEF_OW_W = 24;

endpackage : tt_mux_pkg
`default_nettype wire

// File: rtl/tt_mux_slot_gate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tt_mux_slot_gate                                       |
// | Description : Per-slot input-word gate. Zeroes the word of a         |
// |               disabled slot and forces the project rst_n low while   |
// |               the slot is held in reset; clk passes through.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tt_mux_slot_gate
  import tt_mux_pkg::*;
#(
  parameter int IW_W = DEF_IW_W
) (
  input  logic            i_ena,
  input  logic            i_hold_rst,
  input  logic [IW_W-1:0] i_pad_iw,
  output logic [IW_W-1:0] o_slot_iw
);

  // Pass the pad word only to an enabled slot, overriding rst_n during reset
  always_comb begin
    o_slot_iw = '0;
    if (i_ena) begin
      o_slot_iw = i_pad_iw;
      if (i_hold_rst) begin
        o_slot_iw[IW_RSTN_BIT] = 1'b0;
      end
    end
  end

endmodule : tt_mux_slot_gate
`default_nettype wire

// File: rtl/tt_mux_slot_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tt_mux_slot_ctrl                                       |
// | Description : N_PROJ-slot project mux. Accepts a slot select over a  |
// |               valid/ready handshake, sequences disable -> held reset |
// |               -> run, and routes pad words to/from the active slot.  |
// |               Build option TT_MUX_OUT_REG_EN registers pad_ow.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tt_mux_slot_ctrl
  import tt_mux_pkg::*;
#(
  parameter int N_PROJ     = 4,
  parameter int IW_W       = DEF_IW_W,
  parameter int OW_W       = DEF_OW_W,
  parameter int RST_CYCLES = 4,
  parameter int SEL_W      = $clog2(N_PROJ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel_valid,
  output logic                   sel_ready,
  input  logic [SEL_W-1:0]       sel_addr,
  input  logic                   sel_off,
  input  logic [IW_W-1:0]        pad_iw,
  output logic [OW_W-1:0]        pad_ow,
  output logic [N_PROJ-1:0]      proj_ena,
  output logic [N_PROJ*IW_W-1:0] proj_iw,
  input  logic [N_PROJ*OW_W-1:0] proj_ow,
  output logic [SEL_W-1:0]       cur_sel,
  output logic                   running,
  output logic                   sel_err
);

  // Reset-hold counter is loaded with RST_CYCLES-1 so RESET lasts RST_CYCLES cycles
  localparam logic [7:0] c_rst_load = 8'(RST_CYCLES - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              run_q, run_d;
  logic              hold_q, hold_d;
  logic [N_PROJ-1:0] ena_q, ena_d;
  logic              accept;
  logic              addr_ok;
  logic              active_d;
  logic [OW_W-1:0]   ow_mux;

  assign accept  = sel_valid && ready_q;
  assign addr_ok = (32'(sel_addr) < 32'(N_PROJ));

  // Next-state, latched selection and registered-output decode
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (accept && !sel_off) begin
          if (addr_ok) begin
            cur_sel_d = sel_addr;
            state_d   = OFF;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      OFF: begin
        state_d = RESET;
        cnt_d   = c_rst_load;
      end
      RESET: begin
        if (cnt_q == 8'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RUN: begin
        if (accept) begin
          if (sel_off) begin
            state_d = IDLE;
          end else if (addr_ok) begin
            cur_sel_d = sel_addr;
            state_d   = OFF;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d  = (state_d == IDLE) || (state_d == RUN);
    run_d    = (state_d == RUN);
    hold_d   = (state_d == RESET);
    active_d = (state_d == RESET) || (state_d == RUN);
    ena_d    = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      ena_d[k] = active_d && (cur_sel_d == SEL_W'(k));
    end
  end

  // Controller state and registered status/enable outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_sel_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      run_q     <= 1'b0;
      hold_q    <= 1'b0;
      ena_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      run_q     <= run_d;
      hold_q    <= hold_d;
      ena_q     <= ena_d;
    end
  end

  assign sel_ready = ready_q;
  assign cur_sel   = cur_sel_q;
  assign running   = run_q;
  assign sel_err   = err_q;
  assign proj_ena  = ena_q;

  // Per-slot input-word gating
  for (genvar k = 0; k < N_PROJ; k++) begin : g_slot
    tt_mux_slot_gate #(
      .IW_W (IW_W)
    ) u_gate (
      .i_ena      (ena_q[k]),
      .i_hold_rst (hold_q),
      .i_pad_iw   (pad_iw),
      .o_slot_iw  (proj_iw[k*IW_W +: IW_W])
    );
  end

  // Select the output word of the latched slot
  always_comb begin
    ow_mux = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      if (cur_sel_q == SEL_W'(k)) begin
        ow_mux = proj_ow[k*OW_W +: OW_W];
      end
    end
  end

`ifdef TT_MUX_OUT_REG_EN
  logic [OW_W-1:0] pad_ow_q, pad_ow_d;

  // Capture only while RUN continues, so the first OFF cycle after a switch reads zero
  always_comb begin
    pad_ow_d = '0;
    if ((state_q == RUN) && (state_d == RUN)) begin
      pad_ow_d = ow_mux;
    end
  end

  // Registered pad output word
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_ow_q <= '0;
    end else begin
      pad_ow_q <= pad_ow_d;
    end
  end

  assign pad_ow = pad_ow_q;
`else
  assign pad_ow = run_q ? ow_mux : '0;
`endif

endmodule : tt_mux_slot_ctrl
`default_nettype wire

// File: tb/tb_tt_mux_slot_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_tt_mux_slot_ctrl                                    |
// | Description : Self-checking bench for tt_mux_slot_ctrl. A sequence-  |
// |               age model predicts every output each cycle; directed   |
// |               steps pin literal values, then random traffic runs.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_tt_mux_slot_ctrl;

  localparam int N   = 4;
  localparam int SW  = 3;   // wide enough to express out-of-range addresses
  localparam int IWW = 18;
  localparam int OWW = 24;
  localparam int RC  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           sel_valid;
  logic           sel_ready;
  logic [SW-1:0]  sel_addr;
  logic           sel_off;
  logic [IWW-1:0] pad_iw;
  logic [OWW-1:0] pad_ow;
  logic [N-1:0]   proj_ena;
  logic [N*IWW-1:0] proj_iw;
  logic [N*OWW-1:0] proj_ow;
  logic [SW-1:0]  cur_sel;
  logic           running;
  logic           sel_err;

  int n_checks = 0;
  int n_fail   = 0;

  tt_mux_slot_ctrl #(
    .N_PROJ     (N),
    .IW_W       (IWW),
    .OW_W       (OWW),
    .RST_CYCLES (RC),
    .SEL_W      (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .sel_addr  (sel_addr),
    .sel_off   (sel_off),
    .pad_iw    (pad_iw),
    .pad_ow    (pad_ow),
    .proj_ena  (proj_ena),
    .proj_iw   (proj_iw),
    .proj_ow   (proj_ow),
    .cur_sel   (cur_sel),
    .running   (running),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a sequence age counts cycles since an accepted
  // select (1 = disabled cycle, 2..RC+1 = held reset, RC+2 = running).
  bit             m_started = 1'b0;
  bit             m_active;
  int             m_sel;
  int             m_age;
  bit             m_err;
  logic [OWW-1:0] m_pad_reg;

  always @(posedge clk) begin : p_model
    bit run_before;
    bit run_after;
    int idx;
    if (rst) begin
      m_started = 1'b1;
      m_active  = 1'b0;
      m_sel     = 0;
      m_age     = 0;
      m_err     = 1'b0;
      m_pad_reg = '0;
    end else if (m_started) begin
      run_before = m_active && (m_age >= RC + 2);
      idx        = m_sel;
      if (sel_valid && (!m_active || run_before)) begin
        if (sel_off) begin
          m_active = 1'b0;
        end else if (int'(sel_addr) < N) begin
          m_active = 1'b1;
          m_sel    = int'(sel_addr);
          m_age    = 1;
        end else begin
          m_err    = 1'b1;
          m_active = 1'b0;
        end
      end else if (m_active && (m_age < RC + 2)) begin
        m_age++;
      end
      run_after = m_active && (m_age >= RC + 2);
      m_pad_reg = (run_before && run_after) ? proj_ow[idx*OWW +: OWW] : '0;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin : p_compare
    bit               e_run;
    bit               e_en;
    logic [N-1:0]     e_ena;
    logic [N*IWW-1:0] e_iw;
    logic [OWW-1:0]   e_pad;
    if (m_started) begin
      e_run = m_active && (m_age >= RC + 2);
      e_en  = m_active && (m_age >= 2);
      e_ena = e_en ? (N'(1) << m_sel) : '0;
      e_iw  = '0;
      if (e_en) begin
        e_iw[m_sel*IWW +: IWW] = (m_age <= RC + 1) ? (pad_iw & ~18'h2) : pad_iw;
      end
`ifdef TT_MUX_OUT_REG_EN
      e_pad = m_pad_reg;
`else
      e_pad = e_run ? proj_ow[m_sel*OWW +: OWW] : '0;
`endif
      check("m_ready",   128'(sel_ready), 128'(!m_active || e_run));
      check("m_running", 128'(running),   128'(e_run));
      check("m_ena",     128'(proj_ena),  128'(e_ena));
      check("m_iw",      128'(proj_iw),   128'(e_iw));
      check("m_pad_ow",  128'(pad_ow),    128'(e_pad));
      check("m_cur_sel", 128'(cur_sel),   128'(SW'(m_sel)));
      check("m_err",     128'(sel_err),   128'(m_err));
    end
  end

  int runc;
  int lowc;

  initial begin
    rst       = 1'b1;
    sel_valid = 1'b0;
    sel_off   = 1'b0;
    sel_addr  = '0;
    pad_iw    = 18'h3FFFF;
    proj_ow   = {24'h0F0F0F, 24'hA5A5A5, 24'h123456, 24'h654321};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ena",     128'(proj_ena),  128'(0));
    check("rst_iw",      128'(proj_iw),   128'(0));
    check("rst_pad_ow",  128'(pad_ow),    128'(0));
    check("rst_ready",   128'(sel_ready), 128'(1));
    check("rst_running", 128'(running),   128'(0));
    #2 rst = 1'b0;

    // Select slot 2: one OFF cycle, four held-reset cycles, then RUN
    @(negedge clk);
    #2 sel_valid = 1'b1; sel_addr = 3'd2;
    @(negedge clk);
    check("off_ena",   128'(proj_ena),  128'(0));
    check("off_iw",    128'(proj_iw),   128'(0));
    check("off_ready", 128'(sel_ready), 128'(0));
    #2 sel_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("hold_word", 128'(proj_iw[2*IWW +: IWW]), 128'(18'h3FFFD));
      check("hold_ena",  128'(proj_ena), 128'(4'b0100));
    end
    @(negedge clk);
    check("run_word",    128'(proj_iw[2*IWW +: IWW]), 128'(18'h3FFFF));
    check("run_running", 128'(running), 128'(1));
`ifdef TT_MUX_OUT_REG_EN
    check("run_pad_first", 128'(pad_ow), 128'(0));
`else
    check("run_pad_first", 128'(pad_ow), 128'(24'hA5A5A5));
`endif
    @(negedge clk);
    check("run_pad", 128'(pad_ow), 128'(24'hA5A5A5));

    // Re-select the same slot: running low 5 cycles, rst_n low 4 of them
    #2 sel_valid = 1'b1; sel_addr = 3'd2;
    runc = 0;
    lowc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (running) runc++;
      if (proj_ena[2] && !proj_iw[2*IWW + 1]) lowc++;
      if (i == 0) #2 sel_valid = 1'b0;
    end
    check("resel_running_cycles", 128'(runc), 128'(0));
    check("resel_rstn_low_cycles", 128'(lowc), 128'(4));
    @(negedge clk);
    check("resel_back", 128'(running), 128'(1));

    // Command held through OFF/RESET is taken on the first RUN cycle
    #2 sel_valid = 1'b1; sel_addr = 3'd1;
    @(negedge clk);
    #2 sel_addr = 3'd3;
    repeat (4) begin
      @(negedge clk);
      check("held_ready", 128'(sel_ready), 128'(0));
      check("held_sel",   128'(cur_sel),   128'(1));
    end
    @(negedge clk);
    check("held_run",     128'(running), 128'(1));
    check("held_run_sel", 128'(cur_sel), 128'(1));
    @(negedge clk);
    check("held_taken",   128'(running), 128'(0));
    check("held_new_sel", 128'(cur_sel), 128'(3));
    #2 sel_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("slot3_run", 128'(running), 128'(1));

    // Out-of-range address while running
    #2 sel_valid = 1'b1; sel_addr = 3'd5;
    @(negedge clk);
    check("oor_err",   128'(sel_err),   128'(1));
    check("oor_ena",   128'(proj_ena),  128'(0));
    check("oor_ready", 128'(sel_ready), 128'(1));
    check("oor_sel",   128'(cur_sel),   128'(3));
    #2 sel_addr = 3'd0;
    @(negedge clk);
    #2 sel_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("after_err_run",    128'(running),  128'(1));
    check("after_err_sticky", 128'(sel_err),  128'(1));
    check("after_err_ena",    128'(proj_ena), 128'(4'b0001));

    // Reset asserted during RESET
    #2 sel_valid = 1'b1; sel_addr = 3'd1;
    @(negedge clk);
    #2 sel_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midrst_ena",   128'(proj_ena),  128'(0));
    check("midrst_iw",    128'(proj_iw),   128'(0));
    check("midrst_err",   128'(sel_err),   128'(0));
    check("midrst_sel",   128'(cur_sel),   128'(0));
    check("midrst_ready", 128'(sel_ready), 128'(1));
    #2 rst = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #2;
      rst       = ($urandom_range(0, 299) == 0);
      sel_valid = ($urandom_range(0, 3) == 0);
      sel_off   = ($urandom_range(0, 9) == 0);
      sel_addr  = SW'($urandom_range(0, 7));
      pad_iw    = IWW'($urandom);
      proj_ow   = {$urandom, $urandom, $urandom};
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tt_mux_slot_ctrl
`default_nettype wire
